fighter_health_ctrl: RTL and testbench
======================================

Name: fighter_health_ctrl

Overview:
- Producer of the per-player health values that the status bar renderer consumes.
- Accepts hit events from the combat logic through a valid/ready handshake and applies saturating damage.
- Enforces an invulnerability window after each hit.
- On a KO, waits for the renderer's animated (final) health to catch up before asserting KO and the winner.
- Sits between the hitbox/combat logic and the status bar: drives curr_health_l/r and reads back final_health_l/r.

Parameters:
- MAX_HEALTH, 300, health loaded at reset and at round start (must be <= 511).
- INVULN_CYCLES, 25_000_000, clk cycles a player ignores hits after an accepted hit (0.25 s at 100 MHz).
- KO_TIMEOUT, 200_000_000, maximum clk cycles spent in KO_WAIT before forcing KO.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- round_start  in  1  single-cycle pulse: (re)start a round.
- hit_valid_l  in  1  hit on left player offered.
- hit_dmg_l  in  8  damage of the left hit.
- hit_ready_l  out  1  left hit can be accepted this cycle.
- hit_valid_r  in  1  hit on right player offered.
- hit_dmg_r  in  8  damage of the right hit.
- hit_ready_r  out  1  right hit can be accepted this cycle.
- final_health_l  in  9  displayed (animated) left health from the status bar.
- final_health_r  in  9  displayed (animated) right health from the status bar.
- curr_health_l  out  9  authoritative left health.
- curr_health_r  out  9  authoritative right health.
- round_active  out  1  high in FIGHT.
- ko  out  1  high in KO.
- winner  out  2  00 none, 01 left wins, 10 right wins, 11 draw.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE, curr_health_l/r = MAX_HEALTH.
  - Invulnerability counters = 0, timeout counter = 0.
  - hit_ready_l/r = 0, round_active = 0, ko = 0, winner = 00.
  - Reset takes priority over every other input, including mid-round and mid-KO_WAIT.
- States: IDLE, FIGHT, KO_WAIT, KO. All outputs are registered.
- round_start (any state, including FIGHT): next state FIGHT. Health is reloaded to MAX_HEALTH, counters are cleared, and winner = 00. Any hit offered in the same cycle is ignored.
- FIGHT:
  - hit_ready_x = 1 exactly when invuln_x == 0. Ready is combinational from the counter, not from valid.
  - A hit is accepted when hit_valid_x & hit_ready_x. On the next edge:
    - curr_health_x <= (curr_health_x > dmg) ? curr_health_x - dmg : 0. This is a 9-bit saturating subtract with dmg zero-extended.
    - invuln_x <= INVULN_CYCLES.
  - A zero-damage hit is still accepted and still loads invulnerability.
  - invuln_x decrements by 1 each cycle while nonzero. hit_ready_x therefore returns high INVULN_CYCLES cycles after the accepting edge.
  - Left and right channels are independent. Simultaneous hits in one cycle are both applied.
  - When either updated health equals 0: next state KO_WAIT. Winner is latched from the post-update values: left 0 and right 0 → 11, left 0 only → 10, right 0 only → 01.
- KO_WAIT:
  - hit_ready_l/r = 0, round_active = 0, health frozen.
  - Timeout counter increments each cycle.
  - Go to KO when (final_health_l == curr_health_l && final_health_r == curr_health_r), or when the counter reaches KO_TIMEOUT-1.
- KO: ko = 1, winner held, hit_ready_l/r = 0. Leaves only on round_start or reset.
- IDLE: hit_ready_l/r = 0. Leaves only on round_start.
- Latencies:
  - Accepted hit → curr_health updated: 1 cycle.
  - Lethal hit → KO_WAIT: 1 cycle.
  - Match condition in KO_WAIT → ko high: 1 cycle.
- Counter widths: $clog2(INVULN_CYCLES+1) and $clog2(KO_TIMEOUT+1).

Decomposition:
- Shared package fighter_pkg:
  - State encoding (2-bit): IDLE=0, FIGHT=1, KO_WAIT=2, KO=3.
  - Winner codes WIN_NONE/WIN_L/WIN_R/WIN_DRAW.
  - HEALTH_W = 9, DMG_W = 8.
- Sub-module health_channel, instantiated twice (left, right):
  - Contents: health register, saturating subtract, invulnerability counter, ready generation.
  - Inputs: enable (state==FIGHT), reload.
  - Outputs: health, ready, a next-health-is-zero flag.
- The top level holds the FSM, winner latch and timeout counter.

Test Plan:
Simulation parameters: MAX_HEALTH=100, INVULN_CYCLES=4, KO_TIMEOUT=16.
- Reset then round_start → next cycle round_active=1, curr_health_l/r=100, hit_ready_l/r=1, winner=00.
- hit_valid_l with dmg=30 held high for 10 cycles:
  - First accept → health_l=70, hit_ready_l low for exactly 4 cycles.
  - Second accept → health_l=40.
  - Right channel unaffected.
- Left health 20, dmg=50 → health_l=0 (saturates, no wrap), state KO_WAIT, hit_ready=0. Drive final_health_l=0 and final_health_r=curr_health_r → ko=1 next cycle, winner=10.
- Both players at 10, simultaneous hits of dmg 10 → both 0, winner=11; KO_WAIT entered.
- KO_WAIT with final_health never matching → ko asserts after 16 cycles. round_start then → health 100/100, winner=00, ko=0.
- round_start mid-FIGHT while invuln_l=3 and hit_valid_r high → health reloaded to 100, hit_ready_l=1 next cycle, right hit ignored. Separately, rst_n low during KO_WAIT → IDLE with all outputs at reset values.

Source files
------------

// File: rtl/fighter_health_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fighter_pkg
//   Shared definitions for the fighter health controller: datapath widths,
//   FSM state encoding, winner codes and the saturating damage subtract.
// ----------------------------------------------------------------------------
package fighter_pkg;

  localparam int HEALTH_W = 9;
  localparam int DMG_W    = 8;

  // FSM state encoding (kept as plain 2-bit constants so legacy code that
  // compares raw state bits keeps working).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FIGHT   = 2'd1;
  localparam logic [1:0] ST_KO_WAIT = 2'd2;
  localparam logic [1:0] ST_KO      = 2'd3;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_L    = 2'b01,
    WIN_R    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Health minus zero-extended damage, clamped at zero.
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] h,
                                                  input logic [DMG_W-1:0]    d);
    logic [HEALTH_W-1:0] d_ext;
    d_ext = {{(HEALTH_W-DMG_W){1'b0}}, d};
    return (h > d_ext) ? (h - d_ext) : '0;
  endfunction

  // Winner from the post-hit "health is zero" flags of both players.
  function automatic winner_t winner_code(input logic l_zero, input logic r_zero);
    if (l_zero && r_zero) return WIN_DRAW;
    else if (l_zero)      return WIN_R;
    else if (r_zero)      return WIN_L;
    else                  return WIN_NONE;
  endfunction

endpackage

// File: rtl/fighter_health_ctrl_if.sv
// ----------------------------------------------------------------------------
// fighter_health_ctrl_if
//   Bundles the combat-side hit handshakes, the status-bar health loop and
//   the round status outputs of the health controller.
//   master : combat logic / status bar side (drives hits, round_start,
//            final_health; observes everything else)
//   slave  : the health controller itself
// ----------------------------------------------------------------------------
interface fighter_health_ctrl_if;
  import fighter_pkg::*;

  logic                round_start;
  logic                hit_valid_l;
  logic [DMG_W-1:0]    hit_dmg_l;
  logic                hit_ready_l;
  logic                hit_valid_r;
  logic [DMG_W-1:0]    hit_dmg_r;
  logic                hit_ready_r;
  logic [HEALTH_W-1:0] final_health_l;
  logic [HEALTH_W-1:0] final_health_r;
  logic [HEALTH_W-1:0] curr_health_l;
  logic [HEALTH_W-1:0] curr_health_r;
  logic                round_active;
  logic                ko;
  logic [1:0]          winner;

  modport master (
    output round_start,
    output hit_valid_l, hit_dmg_l, hit_valid_r, hit_dmg_r,
    output final_health_l, final_health_r,
    input  hit_ready_l, hit_ready_r,
    input  curr_health_l, curr_health_r,
    input  round_active, ko, winner
  );

  modport slave (
    input  round_start,
    input  hit_valid_l, hit_dmg_l, hit_valid_r, hit_dmg_r,
    input  final_health_l, final_health_r,
    output hit_ready_l, hit_ready_r,
    output curr_health_l, curr_health_r,
    output round_active, ko, winner
  );

endinterface

// File: rtl/fighter_health_ctrl_channel.sv
// ----------------------------------------------------------------------------
// health_channel
//   One player's health: health register, saturating damage subtract,
//   invulnerability counter and hit-ready generation.
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : round is in FIGHT; hits only accepted while high
//   reload     : round (re)start; reload health, clear invulnerability,
//                and ignore any hit offered in the same cycle
//   hit_valid, hit_dmg : offered hit
//   health     : registered current health
//   ready      : hit can be accepted this cycle
//   next_zero  : health after this cycle's update will be zero
// ----------------------------------------------------------------------------
module health_channel
  import fighter_pkg::*;
#(
  parameter int MAX_HEALTH    = 300,
  parameter int INVULN_CYCLES = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                reload,
  input  logic                hit_valid,
  input  logic [DMG_W-1:0]    hit_dmg,
  output logic [HEALTH_W-1:0] health,
  output logic                ready,
  output logic                next_zero
);

  localparam int INV_W = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
  localparam logic [INV_W-1:0]    INV_LOAD  = INV_W'(INVULN_CYCLES);
  localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);

  logic [HEALTH_W-1:0] health_reg, health_next;
  logic [INV_W-1:0]    invuln_reg, invuln_next;
  logic                accept;

  // Ready depends only on the counter (and round state), never on valid.
  assign ready  = enable && (invuln_reg == '0);
  assign accept = ready && hit_valid && !reload;

  always_comb begin
    health_next = health_reg;
    invuln_next = (invuln_reg != '0) ? invuln_reg - 1'b1 : invuln_reg;
    if (reload) begin
      health_next = HEALTH_INIT;
      invuln_next = '0;
    end else if (accept) begin
      // Zero-damage hits still start a fresh invulnerability window.
      health_next = sat_sub(health_reg, hit_dmg);
      invuln_next = INV_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      health_reg <= HEALTH_INIT;
      invuln_reg <= '0;
    end else begin
      health_reg <= health_next;
      invuln_reg <= invuln_next;
    end
  end

  assign health    = health_reg;
  assign next_zero = (health_next == '0);

endmodule

// File: rtl/fighter_health_ctrl.sv
// ----------------------------------------------------------------------------
// fighter_health_ctrl
//   Per-player health producer for the status bar. Accepts hits over a
//   valid/ready handshake, applies saturating damage with a per-player
//   invulnerability window, and on a KO waits for the status bar's animated
//   health to catch up (or a timeout) before asserting ko and the winner.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of fighter_health_ctrl_if (round_start, hit
//           handshakes, final_health_l/r in; curr_health_l/r,
//           round_active, ko, winner out)
// ----------------------------------------------------------------------------
module fighter_health_ctrl
  import fighter_pkg::*;
#(
  parameter int MAX_HEALTH    = 300,
  parameter int INVULN_CYCLES = 25_000_000,
  parameter int KO_TIMEOUT    = 200_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fighter_health_ctrl_if.slave bus
);

  localparam int TO_W = (KO_TIMEOUT > 1) ? $clog2(KO_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(KO_TIMEOUT - 1);

  logic [1:0]          state_reg, state_next;
  winner_t             winner_reg, winner_next;
  logic [TO_W-1:0]     ko_cnt_reg, ko_cnt_next;
  logic                round_active_reg, ko_reg;

  // Index 0 = left player, 1 = right player.
  logic [1:0]          hit_valid;
  logic [DMG_W-1:0]    hit_dmg   [2];
  logic [HEALTH_W-1:0] health    [2];
  logic [1:0]          ready;
  logic [1:0]          next_zero;
  logic                fight;
  logic                health_match;

  assign hit_valid  = {bus.hit_valid_r, bus.hit_valid_l};
  assign hit_dmg[0] = bus.hit_dmg_l;
  assign hit_dmg[1] = bus.hit_dmg_r;
  assign fight      = (state_reg == ST_FIGHT);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      health_channel #(
        .MAX_HEALTH    (MAX_HEALTH),
        .INVULN_CYCLES (INVULN_CYCLES)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (fight),
        .reload    (bus.round_start),
        .hit_valid (hit_valid[gi]),
        .hit_dmg   (hit_dmg[gi]),
        .health    (health[gi]),
        .ready     (ready[gi]),
        .next_zero (next_zero[gi])
      );
    end
  endgenerate

  // The renderer has caught up once its animated values equal ours.
  assign health_match = (bus.final_health_l == health[0]) &&
                        (bus.final_health_r == health[1]);

  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    ko_cnt_next = '0;
    if (bus.round_start) begin
      state_next  = ST_FIGHT;
      winner_next = WIN_NONE;
    end else begin
      case (state_reg)
        ST_FIGHT: begin
          // Winner is captured from the post-hit values on the KO edge.
          if (next_zero != 2'b00) begin
            state_next  = ST_KO_WAIT;
            winner_next = winner_code(next_zero[0], next_zero[1]);
          end
        end
        ST_KO_WAIT: begin
          ko_cnt_next = ko_cnt_reg + 1'b1;
          if (health_match || (ko_cnt_reg == TO_LAST)) begin
            state_next = ST_KO;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      winner_reg       <= WIN_NONE;
      ko_cnt_reg       <= '0;
      round_active_reg <= 1'b0;
      ko_reg           <= 1'b0;
    end else begin
      state_reg        <= state_next;
      winner_reg       <= winner_next;
      ko_cnt_reg       <= ko_cnt_next;
      round_active_reg <= (state_next == ST_FIGHT);
      ko_reg           <= (state_next == ST_KO);
    end
  end

  assign bus.hit_ready_l   = ready[0];
  assign bus.hit_ready_r   = ready[1];
  assign bus.curr_health_l = health[0];
  assign bus.curr_health_r = health[1];
  assign bus.round_active  = round_active_reg;
  assign bus.ko            = ko_reg;
  assign bus.winner        = winner_reg;

endmodule

// File: tb/tb_fighter_health_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fighter_health_ctrl
//   Directed testbench for fighter_health_ctrl with MAX_HEALTH=100,
//   INVULN_CYCLES=4, KO_TIMEOUT=16. Inputs change and outputs are sampled
//   1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_fighter_health_ctrl;

  localparam int MH = 100;
  localparam int IC = 4;
  localparam int KT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fighter_health_ctrl_if bus();

  fighter_health_ctrl #(
    .MAX_HEALTH    (MH),
    .INVULN_CYCLES (IC),
    .KO_TIMEOUT    (KT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vl, input logic [7:0] dl,
                       input logic vr, input logic [7:0] dr);
    bus.hit_valid_l = vl;
    bus.hit_dmg_l   = dl;
    bus.hit_valid_r = vr;
    bus.hit_dmg_r   = dr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (bus.curr_health_l !== 9'd100) begin n_bad++; $display("FAIL reset_health_l got %0d exp 100", bus.curr_health_l); end
    n_cmp++; if (bus.curr_health_r !== 9'd100) begin n_bad++; $display("FAIL reset_health_r got %0d exp 100", bus.curr_health_r); end
    n_cmp++; if ({bus.hit_ready_l, bus.hit_ready_r} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b exp 00", {bus.hit_ready_l, bus.hit_ready_r}); end
    n_cmp++; if ({bus.round_active, bus.ko, bus.winner} !== 4'b0000) begin n_bad++; $display("FAIL reset_status got %b exp 0000", {bus.round_active, bus.ko, bus.winner}); end
    rst_n = 1'b1;
    step();
    step();
    n_cmp++; if ({bus.round_active, bus.hit_ready_l} !== 2'b00) begin n_bad++; $display("FAIL idle_hold got %b exp 00", {bus.round_active, bus.hit_ready_l}); end
    $display("test_reset done");
  endtask

  task automatic test_round_start();
    bus.round_start = 1'b1;
    step();
    bus.round_start = 1'b0;
    n_cmp++; if (bus.round_active !== 1'b1) begin n_bad++; $display("FAIL start_active got %b exp 1", bus.round_active); end
    n_cmp++; if ({bus.hit_ready_l, bus.hit_ready_r} !== 2'b11) begin n_bad++; $display("FAIL start_ready got %b exp 11", {bus.hit_ready_l, bus.hit_ready_r}); end
    n_cmp++; if ({bus.curr_health_l, bus.curr_health_r} !== {9'd100, 9'd100}) begin n_bad++; $display("FAIL start_health got %0d/%0d exp 100/100", bus.curr_health_l, bus.curr_health_r); end
    n_cmp++; if (bus.winner !== 2'b00) begin n_bad++; $display("FAIL start_winner got %b exp 00", bus.winner); end
    $display("test_round_start done");
  endtask

  // Valid held for 10 cycles: accepts in cycle 0 and cycle 5.
  task automatic test_hold_hits();
    logic       exp_rdy;
    logic [8:0] exp_h;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'd30, 1'b0, 8'd0);
      exp_rdy = (k == 0) || (k == 5);
      exp_h   = (k == 0) ? 9'd100 : ((k <= 5) ? 9'd70 : 9'd40);
      n_cmp++; if (bus.hit_ready_l !== exp_rdy) begin n_bad++; $display("FAIL hold_ready_l cyc %0d got %b exp %b", k, bus.hit_ready_l, exp_rdy); end
      n_cmp++; if (bus.curr_health_l !== exp_h) begin n_bad++; $display("FAIL hold_health_l cyc %0d got %0d exp %0d", k, bus.curr_health_l, exp_h); end
      step();
    end
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_cmp++; if (bus.curr_health_l !== 9'd40) begin n_bad++; $display("FAIL hold_final_l got %0d exp 40", bus.curr_health_l); end
    n_cmp++; if ({bus.curr_health_r, bus.hit_ready_r} !== {9'd100, 1'b1}) begin n_bad++; $display("FAIL hold_right got %0d/%b exp 100/1", bus.curr_health_r, bus.hit_ready_r); end
    n_cmp++; if (bus.hit_ready_l !== 1'b1) begin n_bad++; $display("FAIL hold_ready_back got %b exp 1", bus.hit_ready_l); end
    $display("test_hold_hits done");
  endtask

  task automatic test_saturate_ko();
    drive(1'b1, 8'd20, 1'b0, 8'd0);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_cmp++; if (bus.curr_health_l !== 9'd20) begin n_bad++; $display("FAIL sat_pre got %0d exp 20", bus.curr_health_l); end
    repeat (4) step();
    drive(1'b1, 8'd50, 1'b0, 8'd0);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_cmp++; if (bus.curr_health_l !== 9'd0) begin n_bad++; $display("FAIL sat_health_l got %0d exp 0", bus.curr_health_l); end
    n_cmp++; if ({bus.round_active, bus.ko, bus.hit_ready_l, bus.hit_ready_r} !== 4'b0000) begin n_bad++; $display("FAIL sat_kowait got %b exp 0000", {bus.round_active, bus.ko, bus.hit_ready_l, bus.hit_ready_r}); end
    n_cmp++; if (bus.winner !== 2'b10) begin n_bad++; $display("FAIL sat_winner_latch got %b exp 10", bus.winner); end
    bus.final_health_l = 9'd0;
    bus.final_health_r = 9'd100;
    step();
    bus.final_health_l = 9'h1FF;
    bus.final_health_r = 9'h1FF;
    n_cmp++; if ({bus.ko, bus.winner} !== 3'b110) begin n_bad++; $display("FAIL sat_ko got %b exp 110", {bus.ko, bus.winner}); end
    n_cmp++; if (bus.curr_health_r !== 9'd100) begin n_bad++; $display("FAIL sat_health_r got %0d exp 100", bus.curr_health_r); end
    $display("test_saturate_ko done");
  endtask

  task automatic test_draw();
    bus.round_start = 1'b1;
    step();
    bus.round_start = 1'b0;
    drive(1'b1, 8'd90, 1'b1, 8'd90);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_cmp++; if ({bus.curr_health_l, bus.curr_health_r} !== {9'd10, 9'd10}) begin n_bad++; $display("FAIL draw_pre got %0d/%0d exp 10/10", bus.curr_health_l, bus.curr_health_r); end
    repeat (4) step();
    drive(1'b1, 8'd10, 1'b1, 8'd10);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_cmp++; if ({bus.curr_health_l, bus.curr_health_r} !== 18'd0) begin n_bad++; $display("FAIL draw_health got %0d/%0d exp 0/0", bus.curr_health_l, bus.curr_health_r); end
    n_cmp++; if ({bus.round_active, bus.ko, bus.winner} !== 4'b0011) begin n_bad++; $display("FAIL draw_status got %b exp 0011", {bus.round_active, bus.ko, bus.winner}); end
    $display("test_draw done");
  endtask

  // Entered KO_WAIT on the previous edge; final health never matches.
  task automatic test_timeout();
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (bus.ko === 1'b1) break;
    end
    n_cmp++; if (n !== KT) begin n_bad++; $display("FAIL timeout_cycles got %0d exp %0d", n, KT); end
    n_cmp++; if (bus.winner !== 2'b11) begin n_bad++; $display("FAIL timeout_winner got %b exp 11", bus.winner); end
    bus.round_start = 1'b1;
    step();
    bus.round_start = 1'b0;
    n_cmp++; if ({bus.curr_health_l, bus.curr_health_r} !== {9'd100, 9'd100}) begin n_bad++; $display("FAIL restart_health got %0d/%0d exp 100/100", bus.curr_health_l, bus.curr_health_r); end
    n_cmp++; if ({bus.round_active, bus.ko, bus.winner} !== 4'b1000) begin n_bad++; $display("FAIL restart_status got %b exp 1000", {bus.round_active, bus.ko, bus.winner}); end
    $display("test_timeout done");
  endtask

  task automatic test_restart_mid_fight();
    drive(1'b1, 8'd0, 1'b0, 8'd0);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_cmp++; if ({bus.curr_health_l, bus.hit_ready_l} !== {9'd100, 1'b0}) begin n_bad++; $display("FAIL zero_dmg got %0d/%b exp 100/0", bus.curr_health_l, bus.hit_ready_l); end
    step();
    bus.round_start = 1'b1;
    drive(1'b0, 8'd0, 1'b1, 8'd50);
    n_cmp++; if (bus.hit_ready_l !== 1'b0) begin n_bad++; $display("FAIL mid_ready_pre got %b exp 0", bus.hit_ready_l); end
    step();
    bus.round_start = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_cmp++; if ({bus.curr_health_l, bus.curr_health_r} !== {9'd100, 9'd100}) begin n_bad++; $display("FAIL mid_health got %0d/%0d exp 100/100", bus.curr_health_l, bus.curr_health_r); end
    n_cmp++; if ({bus.hit_ready_l, bus.hit_ready_r, bus.round_active} !== 3'b111) begin n_bad++; $display("FAIL mid_ready got %b exp 111", {bus.hit_ready_l, bus.hit_ready_r, bus.round_active}); end
    $display("test_restart_mid_fight done");
  endtask

  task automatic test_reset_in_ko_wait();
    drive(1'b1, 8'd200, 1'b0, 8'd0);
    step();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_cmp++; if ({bus.curr_health_l, bus.round_active, bus.ko} !== {9'd0, 2'b00}) begin n_bad++; $display("FAIL rko_enter got %0d/%b exp 0/00", bus.curr_health_l, {bus.round_active, bus.ko}); end
    step();
    step();
    rst_n = 1'b0;
    step();
    n_cmp++; if ({bus.curr_health_l, bus.curr_health_r} !== {9'd100, 9'd100}) begin n_bad++; $display("FAIL rko_health got %0d/%0d exp 100/100", bus.curr_health_l, bus.curr_health_r); end
    n_cmp++; if ({bus.hit_ready_l, bus.hit_ready_r, bus.round_active, bus.ko, bus.winner} !== 6'b0) begin n_bad++; $display("FAIL rko_status got %b exp 000000", {bus.hit_ready_l, bus.hit_ready_r, bus.round_active, bus.ko, bus.winner}); end
    rst_n = 1'b1;
    repeat (20) step();
    n_cmp++; if ({bus.round_active, bus.ko} !== 2'b00) begin n_bad++; $display("FAIL rko_idle got %b exp 00", {bus.round_active, bus.ko}); end
    $display("test_reset_in_ko_wait done");
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.round_start    = 1'b0;
    bus.final_health_l = 9'h1FF;
    bus.final_health_r = 9'h1FF;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    test_reset();
    test_round_start();
    test_hold_hits();
    test_saturate_ko();
    test_draw();
    test_timeout();
    test_restart_mid_fight();
    test_reset_in_ko_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
